// File: rtl/signed_param_divider_pkg.sv
// Shared types for the signed sequential divider: FSM state encoding and
// the iteration-counter width helper.
package signed_param_divider_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } div_state_t;

   // Counter must hold WIDTH-1; never narrower than one bit.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/signed_param_divider_if.sv
// START/DONE handshake and operand/result bus between the calc controller
// (master) and the signed divider (slave).
interface signed_param_divider_if #(
   parameter int WIDTH = 8
);
   logic                      START;
   logic signed [2*WIDTH-1:0] Dividend;
   logic signed [WIDTH-1:0]   Divisor;
   logic signed [WIDTH-1:0]   Quotient;
   logic signed [WIDTH-1:0]   Remainder;
   logic                      BUSY;
   logic                      DONE;
   logic                      DIV0;
   logic                      OVF;

   modport master (
      output START, Dividend, Divisor,
      input  Quotient, Remainder, BUSY, DONE, DIV0, OVF
   );

   modport slave (
      input  START, Dividend, Divisor,
      output Quotient, Remainder, BUSY, DONE, DIV0, OVF
   );
endinterface

// File: rtl/signed_param_divider_sub_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
// Relies on i_rem < i_div on entry, so the shifted partial remainder is
// below 2*i_div and the sign of the (WIDTH+1)-bit trial is exact.
module signed_param_divider_sub_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   // Shift in next dividend bit, trial-subtract, keep or restore.
   always_comb begin
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_trial = w_shift - {1'b0, i_div};
      if (!w_trial[WIDTH]) begin
         o_rem = w_trial[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end else begin
         o_rem = w_shift[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/signed_param_divider.sv
// Signed sequential divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, with divide-by-zero and overflow detection.
// Optional build macro DIV_SATURATE_EN: error results saturate instead of
// reading zero.
module signed_param_divider
   import signed_param_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                  CLOCK,
   input logic                  RESET_N,
   signed_param_divider_if.slave bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = cnt_w(WIDTH);
   localparam logic [WIDTH-1:0] Q_NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic [W2-1:0] neg_wide(input logic [W2-1:0] x);
      return ~x + W2'(1);
   endfunction

   function automatic logic [WIDTH-1:0] neg_narrow(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

`ifdef DIV_SATURATE_EN
   function automatic logic [WIDTH-1:0] sat_quo(input logic neg);
      return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   div_state_t              r_state;
   logic [CW-1:0]           r_cnt;
   logic signed [W2-1:0]    r_dvd;
   logic signed [WIDTH-1:0] r_dvs;
   logic                    r_sd, r_sv;
   logic [WIDTH-1:0]        r_rem, r_quo, r_dmag;
   logic                    r_div0, r_ovf, r_fix_wait;
   logic signed [WIDTH-1:0] r_o_quo, r_o_rem;
   logic                    r_busy, r_done, r_o_div0, r_o_ovf;

   logic [W2-1:0]           w_dvd_mag;
   logic [WIDTH-1:0]        w_dvs_mag;
   logic                    w_div0, w_pre_ovf;
   logic [WIDTH-1:0]        w_rem_nx, w_quo_nx;
   logic                    w_qneg, w_rng_ovf, w_fin_ovf;
   logic [WIDTH-1:0]        w_fin_quo, w_fin_rem;

   // Operand magnitudes and early error detection from the latched operands.
   always_comb begin
      w_dvd_mag = r_sd ? neg_wide(r_dvd) : r_dvd;
      w_dvs_mag = r_sv ? neg_narrow(r_dvs) : r_dvs;
      w_div0    = (r_dvs == '0);
      w_pre_ovf = (w_dvd_mag[W2-1:WIDTH] >= w_dvs_mag);
   end

   signed_param_divider_sub_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_dmag),
      .o_rem (w_rem_nx),
      .o_quo (w_quo_nx)
   );

   // Sign restoration, signed range check and error-result selection.
   always_comb begin
      w_qneg    = r_sd ^ r_sv;
      w_rng_ovf = w_qneg ? (r_quo > Q_NEG_LIM) : r_quo[WIDTH-1];
      w_fin_ovf = !r_div0 && (r_ovf || w_rng_ovf);
      w_fin_quo = '0;
      w_fin_rem = '0;
      if (r_div0) begin
`ifdef DIV_SATURATE_EN
         w_fin_quo = sat_quo(r_sd);
`endif
      end else if (w_fin_ovf) begin
`ifdef DIV_SATURATE_EN
         w_fin_quo = sat_quo(w_qneg);
`endif
      end else begin
         w_fin_quo = w_qneg ? neg_narrow(r_quo) : r_quo;
         w_fin_rem = r_sd ? neg_narrow(r_rem) : r_rem;
      end
   end

   // Control FSM with registered results; reset aborts any operation.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_sd       <= 1'b0;
         r_sv       <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dmag     <= '0;
         r_div0     <= 1'b0;
         r_ovf      <= 1'b0;
         r_fix_wait <= 1'b0;
         r_o_quo    <= '0;
         r_o_rem    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_o_div0   <= 1'b0;
         r_o_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.START) begin
                  r_dvd      <= bus.Dividend;
                  r_dvs      <= bus.Divisor;
                  r_sd       <= bus.Dividend[W2-1];
                  r_sv       <= bus.Divisor[WIDTH-1];
                  r_busy     <= 1'b1;
                  r_o_div0   <= 1'b0;
                  r_o_ovf    <= 1'b0;
                  r_fix_wait <= 1'b0;
                  r_state    <= PREP;
               end
            end
            PREP: begin
               r_rem  <= w_dvd_mag[W2-1:WIDTH];
               r_quo  <= w_dvd_mag[WIDTH-1:0];
               r_dmag <= w_dvs_mag;
               r_div0 <= w_div0;
               r_ovf  <= !w_div0 && w_pre_ovf;
               r_cnt  <= CW'(WIDTH - 1);
               r_state <= (w_div0 || w_pre_ovf) ? FIX : ITER;
            end
            ITER: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (r_cnt == '0) r_state <= FIX;
               else             r_cnt   <= r_cnt - CW'(1);
            end
            FIX: begin
               // Error path lingers one extra cycle so its latency is fixed at three edges.
               if ((r_div0 || r_ovf) && !r_fix_wait) begin
                  r_fix_wait <= 1'b1;
               end else begin
                  r_o_quo  <= w_fin_quo;
                  r_o_rem  <= w_fin_rem;
                  r_o_div0 <= r_div0;
                  r_o_ovf  <= w_fin_ovf;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.Quotient  = r_o_quo;
   assign bus.Remainder = r_o_rem;
   assign bus.BUSY      = r_busy;
   assign bus.DONE      = r_done;
   assign bus.DIV0      = r_o_div0;
   assign bus.OVF       = r_o_ovf;

endmodule

// File: tb/tb_signed_param_divider.sv
// Self-checking bench for signed_param_divider at WIDTH=8 and WIDTH=16,
// against an integer-arithmetic reference model.
module tb_signed_param_divider;
   logic CLOCK = 1'b0;
   logic RESET_N = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   signed_param_divider_if #(.WIDTH(8))  b8 ();
   signed_param_divider_if #(.WIDTH(16)) b16 ();

   signed_param_divider #(.WIDTH(8)) u8 (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(b8.slave)
   );
   signed_param_divider #(.WIDTH(16)) u16 (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(b16.slave)
   );

   always #5 CLOCK = ~CLOCK;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: exact integer division, truncating toward zero.
   function automatic void model(input int w, input longint dvd, input longint dvs,
                                 output longint q, output longint r,
                                 output logic d0, output logic ov, output int lat);
      longint lim, ad, as;
      logic   qneg;
      lim  = longint'(1) << (w - 1);
      ad   = (dvd < 0) ? -dvd : dvd;
      as   = (dvs < 0) ? -dvs : dvs;
      qneg = (dvd < 0) != (dvs < 0);
      d0 = 1'b0; ov = 1'b0; q = 0; r = 0; lat = w + 2;
      if (dvs == 0) begin
         d0 = 1'b1; lat = 3;
`ifdef DIV_SATURATE_EN
         q = (dvd < 0) ? -lim : lim - 1;
`endif
      end else begin
         q = dvd / dvs;
         r = dvd % dvs;
         if (ad >= (as << w)) lat = 3;
         if (q > lim - 1 || q < -lim) begin
            ov = 1'b1; r = 0; q = 0;
`ifdef DIV_SATURATE_EN
            q = qneg ? -lim : lim - 1;
`endif
         end
      end
   endfunction

   task automatic run8(input longint dvd, input longint dvs, output int lat);
      for (int i = 0; i < 60 && b8.BUSY; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      b8.Dividend = 16'(dvd);
      b8.Divisor  = 8'(dvs);
      b8.START    = 1'b1;
      @(posedge CLOCK);
      #1 b8.START = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLOCK); #1;
         if (b8.DONE) begin lat = k; break; end
      end
   endtask

   task automatic run16(input longint dvd, input longint dvs, output int lat);
      for (int i = 0; i < 60 && b16.BUSY; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      b16.Dividend = 32'(dvd);
      b16.Divisor  = 16'(dvs);
      b16.START    = 1'b1;
      @(posedge CLOCK);
      #1 b16.START = 1'b0;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge CLOCK); #1;
         if (b16.DONE) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLOCK);
      #1;
      n_vec++;
      if ({b8.Quotient, b8.Remainder, b8.BUSY, b8.DONE, b8.DIV0, b8.OVF} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_w8 got q=%h r=%h busy=%b done=%b d0=%b ov=%b need all 0",
                  b8.Quotient, b8.Remainder, b8.BUSY, b8.DONE, b8.DIV0, b8.OVF);
      end
      n_vec++;
      if ({b16.Quotient, b16.Remainder, b16.BUSY, b16.DONE, b16.DIV0, b16.OVF} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_w16 got q=%h r=%h busy=%b done=%b need all 0",
                  b16.Quotient, b16.Remainder, b16.BUSY, b16.DONE);
      end
      @(negedge CLOCK) RESET_N = 1'b1;
   endtask

   task automatic test_directed();
      longint dvd_t[14] = '{100, -100, 100, -100, -256, 256, 1000, 55, -55,
                            -16384, -32768, -1, 7, 32767};
      longint dvs_t[14] = '{7, 7, -7, -7, 2, 2, 2, 0, 0,
                            -128, -128, 1, -128, 127};
      longint eq, er;
      logic   ed, eo;
      int     el, lat;
      run8(100, 7, lat);
      n_vec++;
      if ({b8.Quotient, b8.Remainder, lat} !== {8'h0E, 8'h02, 32'd10}) begin
         n_err++;
         $display("FAIL basic_100_7 got q=%h r=%h edge=%0d need q=0e r=02 edge=10",
                  b8.Quotient, b8.Remainder, lat);
      end
      for (int i = 0; i < 14; i++) begin
         model(8, dvd_t[i], dvs_t[i], eq, er, ed, eo, el);
         run8(dvd_t[i], dvs_t[i], lat);
         n_vec++;
         if ({b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF} !== {eq[7:0], er[7:0], ed, eo}) begin
            n_err++;
            $display("FAIL directed %0d/%0d got q=%h r=%h d0=%b ov=%b need q=%h r=%h d0=%b ov=%b",
                     dvd_t[i], dvs_t[i], b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF,
                     eq[7:0], er[7:0], ed, eo);
         end
         n_vec++;
         if (lat !== el) begin
            n_err++;
            $display("FAIL directed_latency %0d/%0d got edge %0d need %0d",
                     dvd_t[i], dvs_t[i], lat, el);
         end
      end
   endtask

   task automatic test_random();
      logic signed [15:0] s16;
      logic signed [7:0]  s8;
      longint dvd, dvs, eq, er;
      logic   ed, eo;
      int     el, lat;
      for (int i = 0; i < 40; i++) begin
         s16 = 16'($urandom);
         s8  = 8'($urandom);
         if ($urandom_range(0, 9) == 0) s8 = 8'sd0;
         dvd = longint'(s16) >>> $urandom_range(0, 8);
         dvs = longint'(s8);
         model(8, dvd, dvs, eq, er, ed, eo, el);
         run8(dvd, dvs, lat);
         n_vec++;
         if ({b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF, lat} !==
             {eq[7:0], er[7:0], ed, eo, el}) begin
            n_err++;
            $display("FAIL random %0d/%0d got q=%h r=%h d0=%b ov=%b edge=%0d need q=%h r=%h d0=%b ov=%b edge=%0d",
                     dvd, dvs, b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF, lat,
                     eq[7:0], er[7:0], ed, eo, el);
         end
      end
   endtask

   task automatic test_reset_mid();
      longint eq, er;
      logic   ed, eo, seen;
      int     el, lat;
      run8(100, 7, lat);
      for (int i = 0; i < 60 && b8.BUSY; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      b8.Dividend = -16'sd1000;
      b8.Divisor  = 8'sd33;
      b8.START    = 1'b1;
      @(posedge CLOCK);
      #1 b8.START = 1'b0;
      repeat (5) @(posedge CLOCK);
      #2 RESET_N = 1'b0;
      #1;
      n_vec++;
      if ({b8.Quotient, b8.Remainder, b8.BUSY, b8.DONE, b8.DIV0, b8.OVF} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_mid got q=%h r=%h busy=%b done=%b need all 0",
                  b8.Quotient, b8.Remainder, b8.BUSY, b8.DONE);
      end
      seen = 1'b0;
      repeat (3) begin @(posedge CLOCK); #1; if (b8.DONE) seen = 1'b1; end
      @(negedge CLOCK) RESET_N = 1'b1;
      repeat (12) begin @(posedge CLOCK); #1; if (b8.DONE || b8.BUSY) seen = 1'b1; end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort got done/busy activity=%b need 0", seen);
      end
      model(8, -1000, 33, eq, er, ed, eo, el);
      run8(-1000, 33, lat);
      n_vec++;
      if ({b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF, lat} !== {eq[7:0], er[7:0], ed, eo, el}) begin
         n_err++;
         $display("FAIL after_reset got q=%h r=%h edge=%0d need q=%h r=%h edge=%0d",
                  b8.Quotient, b8.Remainder, lat, eq[7:0], er[7:0], el);
      end
   endtask

   task automatic test_back_to_back();
      longint dvd_t[3] = '{100, -1000, 55};
      longint dvs_t[3] = '{7, 33, 0};
      longint eq, er;
      logic   ed, eo;
      int     el, got, edge_n, acc;
      for (int i = 0; i < 60 && b8.BUSY; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      b8.Dividend = 16'(dvd_t[0]);
      b8.Divisor  = 8'(dvs_t[0]);
      b8.START    = 1'b1;
      @(posedge CLOCK);
      edge_n = 0;
      acc = 0;
      for (int i = 0; i < 3; i++) begin
         model(8, dvd_t[i], dvs_t[i], eq, er, ed, eo, el);
         got = -1;
         for (int k = 0; k < 60; k++) begin
            @(posedge CLOCK); edge_n++; #1;
            if (b8.DONE) begin got = edge_n; break; end
         end
         if (i < 2) begin
            b8.Dividend = 16'(dvd_t[i+1]);
            b8.Divisor  = 8'(dvs_t[i+1]);
         end else begin
            b8.START = 1'b0;
         end
         n_vec++;
         if ({b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF, got} !==
             {eq[7:0], er[7:0], ed, eo, acc + el}) begin
            n_err++;
            $display("FAIL back_to_back op%0d got q=%h r=%h d0=%b edge=%0d need q=%h r=%h d0=%b edge=%0d",
                     i, b8.Quotient, b8.Remainder, b8.DIV0, got, eq[7:0], er[7:0], ed, acc + el);
         end
         acc = edge_n + 2;
      end
      repeat (3) @(posedge CLOCK);
      #1;
      n_vec++;
      if ({b8.BUSY, b8.DONE} !== 2'b00) begin
         n_err++;
         $display("FAIL back_to_back_stop got busy=%b done=%b need 0 0", b8.BUSY, b8.DONE);
      end
   endtask

   task automatic test_start_ignored();
      longint eq, er;
      logic   ed, eo;
      int     el, got;
      model(8, 100, 7, eq, er, ed, eo, el);
      for (int i = 0; i < 60 && b8.BUSY; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      b8.Dividend = 16'sd100;
      b8.Divisor  = 8'sd7;
      b8.START    = 1'b1;
      @(posedge CLOCK);
      #1 b8.START = 1'b0;
      got = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLOCK); #1;
         if (k == 2) begin
            b8.START = 1'b1; b8.Dividend = -16'sd100; b8.Divisor = -8'sd7;
         end
         if (k == 6) b8.START = 1'b0;
         if (b8.DONE) begin got = k; break; end
      end
      n_vec++;
      if ({b8.Quotient, b8.Remainder, b8.DIV0, b8.OVF, got} !== {eq[7:0], er[7:0], ed, eo, el}) begin
         n_err++;
         $display("FAIL start_ignored got q=%h r=%h edge=%0d need q=%h r=%h edge=%0d",
                  b8.Quotient, b8.Remainder, got, eq[7:0], er[7:0], el);
      end
      repeat (3) @(posedge CLOCK);
      #1;
      n_vec++;
      if (b8.BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL start_ignored_idle got busy=%b need 0", b8.BUSY);
      end
   endtask

   task automatic test_w16();
      logic signed [31:0] s32;
      logic signed [15:0] s16;
      longint dvd, dvs, eq, er;
      logic   ed, eo;
      int     el, lat;
      run16(100, 7, lat);
      n_vec++;
      if ({b16.Quotient, b16.Remainder, lat} !== {16'h000E, 16'h0002, 32'd18}) begin
         n_err++;
         $display("FAIL w16_100_7 got q=%h r=%h edge=%0d need q=000e r=0002 edge=18",
                  b16.Quotient, b16.Remainder, lat);
      end
      for (int i = 0; i < 12; i++) begin
         s32 = 32'($urandom);
         s16 = 16'($urandom);
         if (i == 0) s16 = 16'sd0;
         dvd = longint'(s32) >>> $urandom_range(0, 16);
         dvs = longint'(s16);
         model(16, dvd, dvs, eq, er, ed, eo, el);
         run16(dvd, dvs, lat);
         n_vec++;
         if ({b16.Quotient, b16.Remainder, b16.DIV0, b16.OVF, lat} !==
             {eq[15:0], er[15:0], ed, eo, el}) begin
            n_err++;
            $display("FAIL w16_random %0d/%0d got q=%h r=%h d0=%b ov=%b edge=%0d need q=%h r=%h d0=%b ov=%b edge=%0d",
                     dvd, dvs, b16.Quotient, b16.Remainder, b16.DIV0, b16.OVF, lat,
                     eq[15:0], er[15:0], ed, eo, el);
         end
      end
   endtask

   initial begin
      b8.START = 1'b0;  b8.Dividend = '0;  b8.Divisor = '0;
      b16.START = 1'b0; b16.Dividend = '0; b16.Divisor = '0;
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      test_back_to_back();
      test_start_ignored();
      test_w16();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
